// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU-op classes and ALU control values.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } statetype;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the FSM's ALU-op class and the R-type funct field to an
// ALU operation. Purely combinational; unknown functs fall back to add.
module mips_aludec
    import mips_pkg::*;
#(
    parameter int OPW = 6,
    parameter int ACW = 3
) (
    input  aluop_t           aluop,
    input  logic [OPW-1:0]   funct,
    output logic [ACW-1:0]   alucontrol
);

    always_comb begin
        alucontrol = ACW'(ALU_ADD);
        case (aluop)
            ALUOP_ADD: alucontrol = ACW'(ALU_ADD);
            ALUOP_SUB: alucontrol = ACW'(ALU_SUB);
            ALUOP_FUNCT: begin
                case (funct)
                    OPW'(FN_ADD): alucontrol = ACW'(ALU_ADD);
                    OPW'(FN_SUB): alucontrol = ACW'(ALU_SUB);
                    OPW'(FN_AND): alucontrol = ACW'(ALU_AND);
                    OPW'(FN_OR):  alucontrol = ACW'(ALU_OR);
                    OPW'(FN_SLT): alucontrol = ACW'(ALU_SLT);
                    default:      alucontrol = ACW'(ALU_ADD);
                endcase
            end
            default: alucontrol = ACW'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control: Moore main FSM driving register enables and datapath
// selects, plus the ALU decoder. Reset forces all write enables low immediately.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int OPW = 6,
    parameter int ACW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   op,
    input  logic [OPW-1:0]   funct,
    input  logic             zero,
    output logic             pcen,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [ACW-1:0]   alucontrol,
    output logic             illegal
);

    statetype state, next_state, dec_state;
    aluop_t   aluop;
    logic     pcwrite, branch;
    logic     irwrite_s, memwrite_s, regwrite_s, illegal_s;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    // Under reset the outputs decode as FETCH, whatever the register holds.
    assign dec_state = rst ? FETCH : state;

    always_comb begin
        next_state = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        illegal_s  = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        case (dec_state)
            FETCH: begin
                irwrite_s  = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                next_state = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OPW'(OP_LW), OPW'(OP_SW): next_state = MEMADR;
                    OPW'(OP_RTYPE):           next_state = EXECUTE;
                    OPW'(OP_BEQ):             next_state = BEQ;
                    OPW'(OP_ADDI):            next_state = ADDIEX;
                    OPW'(OP_J):               next_state = JUMP;
                    default: begin
                        next_state = FETCH;
                        illegal_s  = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OPW'(OP_LW)) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord       = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                regwrite_s = 1'b1;
                regdst     = 1'b1;
            end
            BEQ: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                pcsrc   = 2'b01;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: regwrite_s = 1'b1;
            JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: next_state = FETCH;
        endcase
    end

    assign pcen     = ~rst & (pcwrite | (branch & zero));
    assign irwrite  = ~rst & irwrite_s;
    assign memwrite = ~rst & memwrite_s;
    assign regwrite = ~rst & regwrite_s;
    assign illegal  = ~rst & illegal_s;

    mips_aludec #(.OPW(OPW), .ACW(ACW)) u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed cycle-by-cycle bench: stimulus pushes the expected output vector for
// each cycle; an independent monitor pops and compares on the falling edge.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;

    always #5 clk = ~clk;

    mips_mc_control #(.OPW(6), .ACW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    // {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol,illegal}
    typedef struct {
        logic [15:0] vec;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;
    bit   stim_done = 1'b0;

    function automatic logic [15:0] mk(input bit pe, input bit irw, input bit mw, input bit rw,
                                       input bit io, input bit m2r, input bit rd, input bit asa,
                                       input logic [1:0] asb, input logic [1:0] pcs,
                                       input logic [2:0] alu, input bit ill);
        return {pe, irw, mw, rw, io, m2r, rd, asa, asb, pcs, alu, ill};
    endfunction

    // Hand-derived vectors for the states visited below.
    localparam logic [15:0] V_RST    = 16'b0000_0000_0100_0100; // forced-low enables, FETCH selects
    localparam logic [15:0] V_FETCH  = 16'b1100_0000_0100_0100;
    localparam logic [15:0] V_DECODE = 16'b0000_0000_1100_0100;
    localparam logic [15:0] V_ILLDEC = 16'b0000_0000_1100_0101;
    localparam logic [15:0] V_MEMADR = 16'b0000_0001_1000_0100;
    localparam logic [15:0] V_MEMRD  = 16'b0000_1000_0000_0100;
    localparam logic [15:0] V_MEMWB  = 16'b0001_0100_0000_0100;
    localparam logic [15:0] V_MEMWR  = 16'b0010_1000_0000_0100;
    localparam logic [15:0] V_ALUWB  = 16'b0001_0010_0000_0100;
    localparam logic [15:0] V_ADDIWB = 16'b0001_0000_0000_0100;
    localparam logic [15:0] V_JUMP   = 16'b1000_0000_0010_0100;

    task automatic step(input bit r, input logic [5:0] o, input logic [5:0] f,
                        input bit z, input logic [15:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        rst   = r;
        op    = o;
        funct = f;
        zero  = z;
        step_no++;
        e.vec = v;
        e.tag = step_no;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                       alusrcb, pcsrc, alucontrol, illegal};
                checks++;
                if (act !== e.vec) begin
                    failures++;
                    $display("FAIL step%0d outputs: got %b expected %b", e.tag, act, e.vec);
                end
            end
        end
    end

    initial begin : stimulus
        // two reset cycles
        step(1, 6'b100011, 6'b0, 0, V_RST);
        step(1, 6'b100011, 6'b0, 0, V_RST);
        // lw: 5 cycles
        step(0, 6'b100011, 6'b0, 0, V_FETCH);
        step(0, 6'b100011, 6'b0, 0, V_DECODE);
        step(0, 6'b100011, 6'b0, 0, V_MEMADR);
        step(0, 6'b100011, 6'b0, 0, V_MEMRD);
        step(0, 6'b100011, 6'b0, 0, V_MEMWB);
        // R-type slt: EXECUTE alucontrol 111
        step(0, 6'b000000, 6'b101010, 0, V_FETCH);
        step(0, 6'b000000, 6'b101010, 0, V_DECODE);
        step(0, 6'b000000, 6'b101010, 0, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0));
        step(0, 6'b000000, 6'b101010, 0, V_ALUWB);
        // R-type and, then or, then unknown funct (falls back to add)
        step(0, 6'b000000, 6'b100100, 0, V_FETCH);
        step(0, 6'b000000, 6'b100100, 0, V_DECODE);
        step(0, 6'b000000, 6'b100100, 0, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0));
        step(0, 6'b000000, 6'b100100, 0, V_ALUWB);
        step(0, 6'b000000, 6'b100101, 0, V_FETCH);
        step(0, 6'b000000, 6'b100101, 0, V_DECODE);
        step(0, 6'b000000, 6'b100101, 0, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b001,0));
        step(0, 6'b000000, 6'b100101, 0, V_ALUWB);
        step(0, 6'b000000, 6'b111000, 0, V_FETCH);
        step(0, 6'b000000, 6'b111000, 0, V_DECODE);
        step(0, 6'b000000, 6'b111000, 0, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0));
        step(0, 6'b000000, 6'b111000, 0, V_ALUWB);
        // beq taken
        step(0, 6'b000100, 6'b0, 0, V_FETCH);
        step(0, 6'b000100, 6'b0, 0, V_DECODE);
        step(0, 6'b000100, 6'b0, 1, mk(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
        // beq not taken
        step(0, 6'b000100, 6'b0, 0, V_FETCH);
        step(0, 6'b000100, 6'b0, 0, V_DECODE);
        step(0, 6'b000100, 6'b0, 0, mk(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
        // j
        step(0, 6'b000010, 6'b0, 0, V_FETCH);
        step(0, 6'b000010, 6'b0, 0, V_DECODE);
        step(0, 6'b000010, 6'b0, 0, V_JUMP);
        // illegal opcode: one-cycle pulse in DECODE, back to FETCH
        step(0, 6'b111111, 6'b0, 0, V_FETCH);
        step(0, 6'b111111, 6'b0, 0, V_ILLDEC);
        // addi
        step(0, 6'b001000, 6'b0, 0, V_FETCH);
        step(0, 6'b001000, 6'b0, 0, V_DECODE);
        step(0, 6'b001000, 6'b0, 0, V_MEMADR);
        step(0, 6'b001000, 6'b0, 0, V_ADDIWB);
        // sw complete
        step(0, 6'b101011, 6'b0, 0, V_FETCH);
        step(0, 6'b101011, 6'b0, 0, V_DECODE);
        step(0, 6'b101011, 6'b0, 0, V_MEMADR);
        step(0, 6'b101011, 6'b0, 0, V_MEMWR);
        // sw aborted by reset in MEMADR: no memwrite, restart at FETCH
        step(0, 6'b101011, 6'b0, 1, V_FETCH);
        step(0, 6'b101011, 6'b0, 1, V_DECODE);
        step(1, 6'b101011, 6'b0, 1, V_RST);
        step(0, 6'b101011, 6'b0, 1, V_FETCH);
        step(0, 6'b101011, 6'b0, 1, V_DECODE);
        stim_done = 1'b1;
    end

    initial begin : finisher
        int budget;
        wait (stim_done);
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
